pc_fetch_sequencer: RTL and testbench
=====================================

// Module: pc_fetch_sequencer
// PURPOSE
//   Fetch controller that sequences the program counter register and the instruction-memory port.
//   Drives newPC/enable of the PC register and issues one outstanding IMEM read per instruction.
//   Presents fetched instructions to decode with a valid/ready handshake.
//   Handles branch/jump redirects and exceptions, discarding stale in-flight fetches.
// PARAMETERS
//   RESET_VECTOR  32'h0000_0000  first fetch address after run is asserted
//   EXC_VECTOR    32'h0000_0080  fetch address loaded on exception
//   INSTR_BYTES   4              sequential PC increment
// PORTS
//   clk            in   1   clock, all state on posedge
//   reset_n        in   1   asynchronous, active-low reset
//   run            in   1   level; 1 = fetch, 0 = halt at next instruction boundary
//   pc_q           in   32  current PC from the PC register
//   pc_en          out  1   load strobe to PC register (enable)
//   pc_next        out  32  value loaded into PC register (newPC)
//   imem_req       out  1   IMEM read request
//   imem_addr      out  32  IMEM read address
//   imem_gnt       in   1   IMEM accepted request this cycle
//   imem_rvalid    in   1   IMEM read data valid
//   imem_rdata     in   32  IMEM read data
//   if_valid       out  1   instruction valid to decode
//   if_instr       out  32  fetched instruction
//   if_pc          out  32  address of if_instr
//   if_ready       in   1   decode accepts instruction
//   redirect       in   1   branch taken / jump, one-cycle pulse
//   redirect_pc    in   32  redirect target, bits[1:0] forced to 0
//   exc            in   1   exception, one-cycle pulse, priority over redirect
//   busy           out  1   state != IDLE
// BEHAVIOUR
//   Reset (reset_n=0, async): state=IDLE, kill=0, pc_en=0, pc_next=RESET_VECTOR, imem_req=0,
//     if_valid=0, if_instr=0, if_pc=0, busy=0. Mid-operation reset aborts everything; late rvalid ignored.
//   pc_en, pc_next, imem_req and imem_addr are combinational from state/inputs.
//   if_* and kill are registered. imem_addr = pc_q.
//   States:
//     IDLE: imem_req=0. If run=1: pc_en=1, pc_next=RESET_VECTOR; next=REQ.
//     REQ:  imem_req=1.
//           If gnt=1: next=WAIT.
//           If gnt=0 and run=0: next=IDLE.
//     WAIT: imem_req=0. On rvalid:
//           If kill=1: drop data, clear kill; next = run ? REQ : IDLE.
//           Otherwise: register if_valid=1, if_instr=rdata, if_pc=pc_q; next=HOLD.
//     HOLD: if_valid=1, if_instr/if_pc stable until if_ready=1. On if_ready: if_valid=0 next cycle.
//           If run=1: pc_en=1, pc_next=pc_q+INSTR_BYTES; next=REQ.
//           If run=0: next=IDLE.
//   Redirect/exception, any state except IDLE (ignored in IDLE):
//     exc: target=EXC_VECTOR. Else redirect: target={redirect_pc[31:2],2'b00}.
//     pc_en=1 and pc_next=target same cycle; overrides the sequential increment.
//     REQ with gnt=1 same cycle: next=WAIT, kill=1. REQ with gnt=0: stay REQ; address changes next cycle.
//     WAIT with no rvalid: kill=1, stay WAIT.
//     WAIT with rvalid same cycle: drop data; next=REQ.
//     HOLD: if_valid=0 next cycle even if if_ready=0; next=REQ.
//   Arithmetic: pc_q+INSTR_BYTES is 32-bit modulo; 32'hFFFF_FFFC wraps to 32'h0.
//   At most one outstanding IMEM request. pc_en is never asserted in WAIT except for redirect/exc.
// TESTING
//   1. reset_n=0 then 1, run=1, IMEM 1-cycle gnt / 1-cycle rvalid, if_ready=1
//      -> fetch addrs 0x0,0x4,0x8 in order; if_pc matches; pc_en one pulse per instr.
//   2. if_ready=0 for 5 cycles in HOLD
//      -> if_valid/if_instr/if_pc stable; imem_req=0; pc_en=0 throughout.
//   3. redirect=1, redirect_pc=0x103 while in WAIT, rvalid 2 cycles later
//      -> data dropped, if_valid stays 0; next imem_addr=0x100.
//   4. exc and redirect same cycle
//      -> pc_next=EXC_VECTOR (0x80); next fetch addr 0x80.
//   5. pc_q=0xFFFF_FFFC instruction accepted
//      -> pc_next=0x0; next fetch addr 0x0.
//   6. reset_n=0 while in WAIT, release, rvalid arrives late
//      -> all outputs at reset values; stale data never on if_instr.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//   Fetch controller sitting between the PC register, the instruction-memory
//   port and decode. It loads the PC register (pc_en/pc_next), issues one
//   IMEM read per instruction with at most one read outstanding, and hands
//   each fetched word to decode over a valid/ready handshake. Branch/jump
//   redirects and exceptions reload the PC at once; a read that was already
//   in flight when the redirect arrived is marked stale (kill) and its data
//   is discarded when it returns.
//
// Ports
//   clk, reset_n              clock (posedge) and asynchronous active-low reset
//   run                       1 = keep fetching, 0 = stop at next instruction boundary
//   pc_q                      current value of the external PC register
//   pc_en, pc_next            load strobe and load value for the PC register
//   imem_req, imem_addr       IMEM read request and address (address is pc_q)
//   imem_gnt                  IMEM accepted the request this cycle
//   imem_rvalid, imem_rdata   IMEM read data return
//   if_valid, if_instr, if_pc instruction presented to decode
//   if_ready                  decode accepts the presented instruction
//   redirect, redirect_pc     branch/jump pulse and target (low two bits ignored)
//   exc                       exception pulse, wins over redirect
//   busy                      sequencer is not idle
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
    parameter int unsigned INSTR_BYTES  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic [31:0] pc_q,
    output logic        pc_en,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        exc,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    localparam logic [31:0] INCR = 32'(INSTR_BYTES);

    state_e      state_q, state_d;
    logic        kill_q, kill_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;

    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] seq_pc;

    // Redirects and exceptions are meaningless while idle; the next start
    // always begins from RESET_VECTOR anyway.
    assign flush    = (state_q != S_IDLE) && (exc || redirect);
    assign flush_pc = exc ? EXC_VECTOR : (redirect_pc & 32'hFFFF_FFFC);
    // Plain 32-bit add: the top word wraps back to address zero.
    assign seq_pc   = pc_q + INCR;

    assign imem_addr = pc_q;
    assign busy      = (state_q != S_IDLE);
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;

    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        pc_en      = 1'b0;
        pc_next    = seq_pc;
        imem_req   = 1'b0;

        case (state_q)
            S_IDLE: begin
                pc_next = RESET_VECTOR;
                if (run) begin
                    // Idle is also the reset state; keep the PC register
                    // untouched while reset is still held.
                    pc_en   = reset_n;
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                imem_req = 1'b1;
                if (flush) begin
                    pc_en   = 1'b1;
                    pc_next = flush_pc;
                    // A read granted in the same cycle targets the old PC.
                    if (imem_gnt) begin
                        state_d = S_WAIT;
                        kill_d  = 1'b1;
                    end
                end else if (imem_gnt) begin
                    state_d = S_WAIT;
                end else if (!run) begin
                    state_d = S_IDLE;
                end
            end

            S_WAIT: begin
                if (flush) begin
                    pc_en   = 1'b1;
                    pc_next = flush_pc;
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = run ? S_REQ : S_IDLE;
                    end else begin
                        if_valid_d = 1'b1;
                        if_instr_d = imem_rdata;
                        if_pc_d    = pc_q;
                        state_d    = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (flush) begin
                    pc_en      = 1'b1;
                    pc_next    = flush_pc;
                    if_valid_d = 1'b0;
                    state_d    = S_REQ;
                end else if (if_ready) begin
                    if_valid_d = 1'b0;
                    if (run) begin
                        pc_en   = 1'b1;
                        pc_next = seq_pc;
                        state_d = S_REQ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            kill_q     <= 1'b0;
            if_valid_q <= 1'b0;
            if_instr_q <= 32'h0;
            if_pc_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, run, pc_en, imem_req, imem_gnt, if_valid, if_ready;
    logic        redirect, exc, busy;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc_q, pc_next, imem_addr, if_instr, if_pc, redirect_pc;

    int checks = 0;
    int errors = 0;
    int pc_en_cnt = 0;

    // IMEM model knobs
    logic        gnt_en;
    int          rv_lat;
    int          rv_cnt = 0;
    logic [31:0] rv_addr = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb_q[$];

    pc_fetch_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .pc_q        (pc_q),
        .pc_en       (pc_en),
        .pc_next     (pc_next),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_ready    (if_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .exc         (exc),
        .busy        (busy)
    );

    // External PC register; its reset value deliberately differs from RESET_VECTOR.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) pc_q <= 32'h1234_5670;
        else if (pc_en) pc_q <= pc_next;
    end

    // IMEM: immediate grant when enabled, data rv_lat cycles after the grant.
    // Not reset, so a read issued before reset still returns afterwards.
    assign imem_gnt = imem_req && gnt_en;
    always @(posedge clk) begin
        imem_rvalid <= 1'b0;
        if (rv_cnt != 0) begin
            rv_cnt <= rv_cnt - 1;
            if (rv_cnt == 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= rv_addr ^ 32'hC0DE_0000;
            end
        end
        if (imem_req && imem_gnt) begin
            rv_cnt  <= rv_lat;
            rv_addr <= imem_addr;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_hold(input string nm);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!if_valid && n < 40);
        chk1({nm, "_hold_reached"}, if_valid, 1'b1);
    endtask

    task automatic wait_req(input string nm);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!imem_req && n < 40);
        chk1({nm, "_req_reached"}, imem_req, 1'b1);
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        sb_q.push_back(e);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk1({nm, "_pc_en"},    pc_en,    1'b0);
        chk ({nm, "_pc_next"},  pc_next,  32'h0);
        chk1({nm, "_imem_req"}, imem_req, 1'b0);
        chk1({nm, "_if_valid"}, if_valid, 1'b0);
        chk ({nm, "_if_instr"}, if_instr, 32'h0);
        chk ({nm, "_if_pc"},    if_pc,    32'h0);
        chk1({nm, "_busy"},     busy,     1'b0);
    endtask

    // Monitor: every accepted instruction is matched against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (reset_n === 1'b1) begin
                if (pc_en === 1'b1) pc_en_cnt++;
                if (if_valid === 1'b1 && if_ready === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_xfer actual pc=%h instr=%h required none", if_pc, if_instr);
                    end else begin
                        e = sb_q.pop_front();
                        chk("xfer_pc", if_pc, e.pc);
                        chk("xfer_instr", if_instr, e.instr);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw;
        int   n;
        reset_n = 1'b0; run = 1'b1; if_ready = 1'b1; redirect = 1'b0;
        redirect_pc = 32'h0; exc = 1'b0; gnt_en = 1'b1; rv_lat = 1;
        repeat (2) step();
        chk_reset_outputs("rst");
        run = 1'b0;
        reset_n = 1'b1;
        step();

        // Sequential fetch of 0x0, 0x4, 0x8
        pc_en_cnt = 0;
        push(32'h0, 32'hC0DE_0000);
        push(32'h4, 32'hC0DE_0004);
        push(32'h8, 32'hC0DE_0008);
        run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_hold("t1");
            chk("t1_if_pc", if_pc, 32'(i * 4));
            if (i == 2) run = 1'b0;
        end
        step();
        chk1("t1_idle", busy, 1'b0);
        chk("t1_pc_en_pulses", 32'(pc_en_cnt), 32'd3);

        // Decode stall in HOLD
        if_ready = 1'b0;
        push(32'h0, 32'hC0DE_0000);
        run = 1'b1;
        wait_hold("t2");
        repeat (5) begin
            step();
            chk1("t2_valid", if_valid, 1'b1);
            chk ("t2_pc", if_pc, 32'h0);
            chk ("t2_instr", if_instr, 32'hC0DE_0000);
            chk1("t2_req", imem_req, 1'b0);
            chk1("t2_pc_en", pc_en, 1'b0);
        end
        if_ready = 1'b1;
        run = 1'b0;
        step();

        // Redirect while waiting for read data
        rv_lat = 3;
        push(32'h100, 32'hC0DE_0100);
        run = 1'b1;
        wait_req("t3");
        step();
        chk1("t3_wait_no_req", imem_req, 1'b0);
        redirect = 1'b1;
        redirect_pc = 32'h103;
        #1;
        chk1("t3_pc_en", pc_en, 1'b1);
        chk ("t3_pc_next", pc_next, 32'h100);
        step();
        redirect = 1'b0;
        redirect_pc = 32'h0;
        rv_lat = 1;
        saw = 1'b0;
        n = 0;
        while (!imem_req && n < 20) begin
            if (if_valid) saw = 1'b1;
            step();
            n++;
        end
        chk1("t3_no_stale_valid", saw, 1'b0);
        chk1("t3_refetch_req", imem_req, 1'b1);
        chk ("t3_refetch_addr", imem_addr, 32'h100);
        wait_hold("t3");
        run = 1'b0;
        step();

        // Exception and redirect together while holding an instruction
        if_ready = 1'b0;
        run = 1'b1;
        wait_hold("t4");
        exc = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h200;
        #1;
        chk1("t4_pc_en", pc_en, 1'b1);
        chk ("t4_pc_next", pc_next, 32'h80);
        step();
        exc = 1'b0;
        redirect = 1'b0;
        chk1("t4_valid_dropped", if_valid, 1'b0);
        chk1("t4_req", imem_req, 1'b1);
        chk ("t4_addr", imem_addr, 32'h80);
        push(32'h80, 32'hC0DE_0080);
        if_ready = 1'b1;
        wait_hold("t4");
        run = 1'b0;
        step();

        // Request not granted and run dropped: back to idle
        gnt_en = 1'b0;
        run = 1'b1;
        wait_req("t5i");
        run = 1'b0;
        step();
        chk1("t5i_idle", busy, 1'b0);
        chk1("t5i_no_req", imem_req, 1'b0);

        // Redirect in ungranted REQ to the top word, then wrap to zero
        run = 1'b1;
        wait_req("t5");
        chk("t5_first_addr", imem_addr, 32'h0);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        #1;
        chk1("t5_pc_en", pc_en, 1'b1);
        chk ("t5_pc_next", pc_next, 32'hFFFF_FFFC);
        step();
        redirect = 1'b0;
        redirect_pc = 32'h0;
        chk1("t5_still_req", imem_req, 1'b1);
        chk ("t5_addr", imem_addr, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC, 32'h3F21_FFFC);
        push(32'h0, 32'hC0DE_0000);
        gnt_en = 1'b1;
        wait_hold("t5a");
        chk1("t5_wrap_pc_en", pc_en, 1'b1);
        chk ("t5_wrap_pc_next", pc_next, 32'h0);
        wait_hold("t5b");
        chk("t5_wrap_if_pc", if_pc, 32'h0);
        run = 1'b0;
        step();

        // Reset while a read is outstanding; its data arrives after release
        rv_lat = 3;
        run = 1'b1;
        wait_req("t6");
        step();
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("t6_rst");
        step();
        run = 1'b0;
        step();
        reset_n = 1'b1;
        saw = 1'b0;
        repeat (5) begin
            step();
            if (if_valid) saw = 1'b1;
        end
        chk1("t6_no_stale_valid", saw, 1'b0);
        chk ("t6_instr_clear", if_instr, 32'h0);
        chk1("t6_idle", busy, 1'b0);
        rv_lat = 1;
        push(32'h0, 32'hC0DE_0000);
        run = 1'b1;
        wait_hold("t6r");
        run = 1'b0;
        step();
        step();

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
